cpu_run_ctrl: RTL

Parametrised run controller placed between the testbench clock/reset and the `CPU` core. It gates the core's clock enable to run a program for a programmed number of cycles, until a halt PC is reached, or one cycle per step pulse. It then appends a configurable number of pipeline-drain cycles so that in-flight instructions finish before `done` is raised. It replaces fixed-length cycle loops in benches and can be synthesised for FPGA bring-up.

---
 rtl/cpu_run_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cpu_run_ctrl                                                    |
// | Purpose : Run controller gating the CPU clock enable. Runs the core for a |
// |           programmed cycle count (COUNT), until a halt PC (HALT), or one  |
// |           cycle per step pulse (STEP), then adds DRAIN_CYCLES enabled     |
// |           cycles so in-flight instructions retire before done is raised.  |
// | Option  : RUN_CTRL_WATCHDOG_EN - when defined, a non-zero run_len acts as |
// |           a watchdog in HALT mode (ends in DONE with timeout=1, no drain).|
// | Ports   : clk, rst_n (async, active low)                                  |
// |           start, mode[1:0], run_len[CNT_W], halt_pc[PC_W] - run request   |
// |           step - STEP-mode enable pulse, clr - abort/acknowledge          |
// |           pc[PC_W] - current core PC                                      |
// |           cpu_en, busy, done, timeout, cycle_cnt[CNT_W] - status/control  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module cpu_run_ctrl #(
   parameter int CNT_W        = 32,
   parameter int PC_W         = 32,
   parameter int DRAIN_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] run_len,
   input  logic [PC_W-1:0]  halt_pc,
   input  logic             step,
   input  logic             clr,
   input  logic [PC_W-1:0]  pc,
   output logic             cpu_en,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0]           c_mode_halt  = 2'd1;
   localparam logic [1:0]           c_mode_step  = 2'd2;
   localparam int                   c_drain_w    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [c_drain_w-1:0] c_drain_load = c_drain_w'(DRAIN_CYCLES);
   localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);

   state_t               state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [CNT_W-1:0]     len_q, len_d;
   logic [PC_W-1:0]      halt_pc_q, halt_pc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
   logic [c_drain_w-1:0] drain_q, drain_d;

   logic                 w_is_halt;
   logic                 w_is_step;
   logic [CNT_W-1:0]     w_cnt_after;
   state_t               w_after_run;

   // Mode 3 decodes as COUNT because it is neither HALT nor STEP.
   assign w_is_halt = (mode_q == c_mode_halt);
   assign w_is_step = (mode_q == c_mode_step);

   // With no drain configured the run phase ends straight in DONE.
   assign w_after_run = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

   always_comb begin
      cpu_en      = 1'b0;
      w_cnt_after = cnt_q;
      state_d     = state_q;
      mode_d      = mode_q;
      len_d       = len_q;
      halt_pc_d   = halt_pc_q;
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;
      drain_d     = drain_q;

      // A zero budget in COUNT/STEP must not produce any enabled RUN cycle.
      if (state_q == ST_DRAIN) begin
         cpu_en = 1'b1;
      end else if (state_q == ST_RUN) begin
         if (w_is_halt)            cpu_en = 1'b1;
         else if (len_q == '0)     cpu_en = 1'b0;
         else if (w_is_step)       cpu_en = step;
         else                      cpu_en = 1'b1;
      end

      // Counter value after this edge, saturating at all-ones.
      if (state_q == ST_RUN && cpu_en && !(&cnt_q))
         w_cnt_after = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start && !clr) begin
               mode_d    = mode;
               len_d     = run_len;
               halt_pc_d = halt_pc;
               cnt_d     = '0;
               timeout_d = 1'b0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = w_cnt_after;
            if (w_is_halt) begin
               // A halt match wins over the watchdog in the same cycle.
               if (pc == halt_pc_q) begin
                  state_d = w_after_run;
                  drain_d = c_drain_load;
               end
`ifdef RUN_CTRL_WATCHDOG_EN
               else if (len_q != '0 && w_cnt_after == len_q) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end
`endif
            end else if (w_cnt_after == len_q) begin
               state_d = w_after_run;
               drain_d = c_drain_load;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - c_drain_one;
            if (drain_q == c_drain_one)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort/acknowledge overrides everything; the count is kept for inspection.
      if (clr)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= 2'd0;
         len_q     <= '0;
         halt_pc_q <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         drain_q   <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         len_q     <= len_d;
         halt_pc_q <= halt_pc_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         drain_q   <= drain_d;
      end
   end

   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign timeout   = timeout_q;
   assign cycle_cnt = cnt_q;

endmodule
`default_nettype wire
